// File: rtl/reg_transfer_sched.sv
// Register-file transfer sequencer: arbitrates two command sources and
// drives the register select codes, one bus transfer per cycle, including
// masked multi-register save/restore bursts that strobe memory.
module reg_transfer_sched #(
    parameter int RR_EN  = 1,
    parameter int MASK_W = 11
) (
    input  logic              clk,
    input  logic              r,
    input  logic              req0_valid,
    input  logic [1:0]        req0_op,
    input  logic [3:0]        req0_src,
    input  logic [3:0]        req0_dst,
    input  logic [MASK_W-1:0] req0_mask,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [1:0]        req1_op,
    input  logic [3:0]        req1_src,
    input  logic [3:0]        req1_dst,
    input  logic [MASK_W-1:0] req1_mask,
    output logic              req1_ready,
    output logic              grant_id,
    output logic [3:0]        rso,
    output logic [3:0]        rsi,
    output logic              mem_we,
    output logic              mem_oe,
    output logic [3:0]        mem_ofs,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MOV   = 2'd1,
        S_BURST = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_MOV     = 2'd0,
        OP_RSV     = 2'd1,
        OP_SAVE    = 2'd2,
        OP_RESTORE = 2'd3
    } op_e;

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic              grant_q, grant_d;
    logic [MASK_W-1:0] rem_q, rem_d;
    logic              dir_q, dir_d;
    logic [1:0]        ready_q, ready_d;
    logic [3:0]        rso_q, rso_d;
    logic [3:0]        rsi_q, rsi_d;
    logic              we_q, we_d;
    logic              oe_q, oe_d;
    logic [3:0]        ofs_q, ofs_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              win;
    logic              acc;
    logic              acc_id;
    op_e               cmd_op;
    logic [3:0]        cmd_src;
    logic [3:0]        cmd_dst;
    logic [MASK_W-1:0] cmd_mask;
    logic [MASK_W-1:0] beat_mask;
    logic [3:0]        beat_idx;
    logic [MASK_W-1:0] beat_rem;
    logic              do_beat;

    function automatic logic [3:0] first_set(input logic [MASK_W-1:0] m);
        logic [3:0] idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MASK_W; i++) begin
            if (m[i] && !found) begin
                idx   = 4'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    // Arbitration winner, accepted command mux and current burst beat selection
    always_comb begin
        win = 1'b0;
        unique case ({req1_valid, req0_valid})
            2'b10:   win = 1'b1;
            2'b11:   win = (RR_EN != 0) ? ~last_q : 1'b0;
            default: win = 1'b0;
        endcase
        acc    = (state_q == S_IDLE) &&
                 ((req0_valid && ready_q[0]) || (req1_valid && ready_q[1]));
        acc_id = req1_valid && ready_q[1];
        if (acc_id) begin
            cmd_op   = op_e'(req1_op);
            cmd_src  = req1_src;
            cmd_dst  = req1_dst;
            cmd_mask = req1_mask;
        end else begin
            cmd_op   = op_e'(req0_op);
            cmd_src  = req0_src;
            cmd_dst  = req0_dst;
            cmd_mask = req0_mask;
        end
        beat_mask = (state_q == S_IDLE) ? cmd_mask : rem_q;
        beat_idx  = first_set(beat_mask);
        beat_rem  = beat_mask & ~(MASK_W'(1) << beat_idx);
    end

    // Next state and next registered outputs; outputs reflect what the
    // following cycle shows, so a command accepted now drives next cycle
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        ready_d = '0;
        rso_d   = '0;
        rsi_d   = '0;
        we_d    = 1'b0;
        oe_d    = 1'b0;
        ofs_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        do_beat = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (acc) begin
                    grant_d = acc_id;
                    last_d  = acc_id;
                    busy_d  = 1'b1;
                    state_d = S_MOV;
                    case (cmd_op)
                        OP_MOV: begin
                            if (cmd_src >= 4'd9 || cmd_dst >= 4'd12) begin
                                err_d = 1'b1;
                            end else begin
                                done_d = 1'b1;
                                if (cmd_src != cmd_dst && cmd_src != '0 && cmd_dst != '0) begin
                                    rso_d = cmd_src;
                                    rsi_d = cmd_dst;
                                end
                            end
                        end
                        OP_SAVE, OP_RESTORE: begin
                            // DS/SS/ES cannot be read onto the bus, so saving them is rejected
                            if (cmd_op == OP_SAVE && (cmd_mask >> 8) != '0) begin
                                err_d = 1'b1;
                            end else if (cmd_mask == '0) begin
                                done_d = 1'b1;
                            end else begin
                                dir_d   = (cmd_op == OP_RESTORE);
                                state_d = S_BURST;
                                do_beat = 1'b1;
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_MOV: begin
                state_d = S_IDLE;
            end
            S_BURST: begin
                if (rem_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    busy_d  = 1'b1;
                    ofs_d   = ofs_q + 4'd1;
                    do_beat = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (do_beat) begin
            rem_d  = beat_rem;
            done_d = (beat_rem == '0);
            if (dir_d) begin
                rsi_d = beat_idx + 4'd1;
                oe_d  = 1'b1;
            end else begin
                rso_d = beat_idx + 4'd1;
                we_d  = 1'b1;
            end
        end

        // Ready is offered only for a cycle spent in IDLE, never on a done cycle
        if (state_d == S_IDLE && (req0_valid || req1_valid)) begin
            ready_d[win] = 1'b1;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (r) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            grant_q <= 1'b0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            ready_q <= '0;
            rso_q   <= '0;
            rsi_q   <= '0;
            we_q    <= 1'b0;
            oe_q    <= 1'b0;
            ofs_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            ready_q <= ready_d;
            rso_q   <= rso_d;
            rsi_q   <= rsi_d;
            we_q    <= we_d;
            oe_q    <= oe_d;
            ofs_q   <= ofs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign req0_ready = ready_q[0];
    assign req1_ready = ready_q[1];
    assign grant_id   = grant_q;
    assign rso        = rso_q;
    assign rsi        = rsi_q;
    assign mem_we     = we_q;
    assign mem_oe     = oe_q;
    assign mem_ofs    = ofs_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_reg_transfer_sched.sv
// Directed bench for reg_transfer_sched: single-cycle command table plus
// hand-written burst, arbitration and mid-command reset sequences.
module tb_reg_transfer_sched;

    logic        clk = 1'b0;
    logic        r;
    logic        req0_valid, req1_valid;
    logic [1:0]  req0_op, req1_op;
    logic [3:0]  req0_src, req0_dst, req1_src, req1_dst;
    logic [10:0] req0_mask, req1_mask;
    logic        req0_ready, req1_ready, grant_id, mem_we, mem_oe, busy, done, err;
    logic [3:0]  rso, rsi, mem_ofs;
    logic        fp_r0, fp_r1, fp_grant, fp_we, fp_oe, fp_busy, fp_done, fp_err;
    logic [3:0]  fp_rso, fp_rsi, fp_ofs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_transfer_sched #(.RR_EN(1), .MASK_W(11)) dut (
        .clk(clk), .r(r),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_src(req0_src),
        .req0_dst(req0_dst), .req0_mask(req0_mask), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_src(req1_src),
        .req1_dst(req1_dst), .req1_mask(req1_mask), .req1_ready(req1_ready),
        .grant_id(grant_id), .rso(rso), .rsi(rsi), .mem_we(mem_we), .mem_oe(mem_oe),
        .mem_ofs(mem_ofs), .busy(busy), .done(done), .err(err)
    );

    reg_transfer_sched #(.RR_EN(0), .MASK_W(11)) dut_fp (
        .clk(clk), .r(r),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_src(req0_src),
        .req0_dst(req0_dst), .req0_mask(req0_mask), .req0_ready(fp_r0),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_src(req1_src),
        .req1_dst(req1_dst), .req1_mask(req1_mask), .req1_ready(fp_r1),
        .grant_id(fp_grant), .rso(fp_rso), .rsi(fp_rsi), .mem_we(fp_we), .mem_oe(fp_oe),
        .mem_ofs(fp_ofs), .busy(fp_busy), .done(fp_done), .err(fp_err)
    );

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  src;
        logic [3:0]  dst;
        logic [10:0] mask;
        logic [3:0]  e_rso;
        logic [3:0]  e_rsi;
        logic        e_we;
        logic        e_oe;
        logic        e_done;
        logic        e_err;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        r = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        r = 1'b0;
    endtask

    // Present a command on requester 0, wait (bounded) for acceptance and
    // return at the negedge of the first drive cycle with valid dropped
    task automatic issue(input logic [1:0] op, input logic [3:0] src,
                         input logic [3:0] dst, input logic [10:0] mask);
        bit got;
        req0_op    = op;
        req0_src   = src;
        req0_dst   = dst;
        req0_mask  = mask;
        req0_valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req0_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("ready_timeout", 0, 1);
        @(negedge clk);
        req0_valid = 1'b0;
    endtask

    initial begin
        vec_t       vecs[13];
        logic [3:0] e_save[4];
        logic [3:0] e_rest[3];
        logic       g_rr[4];
        logic       g_fp[4];
        int         ng;
        bit         seen;

        r = 1'b1;
        req0_valid = 1'b0; req0_op = '0; req0_src = '0; req0_dst = '0; req0_mask = '0;
        req1_valid = 1'b0; req1_op = '0; req1_src = '0; req1_dst = '0; req1_mask = '0;

        //            op    src   dst   mask      rso   rsi   we    oe    done  err
        vecs[0]  = '{2'd0, 4'd1, 4'd2, 11'h000, 4'd1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{2'd0, 4'd3, 4'd3, 11'h000, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{2'd0, 4'd0, 4'd4, 11'h000, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{2'd0, 4'd6, 4'd9, 11'h000, 4'd6, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{2'd0, 4'd10, 4'd1, 11'h000, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{2'd0, 4'd2, 4'd12, 11'h000, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{2'd1, 4'd1, 4'd2, 11'h000, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{2'd2, 4'd0, 4'd0, 11'h100, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{2'd2, 4'd0, 4'd0, 11'h000, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{2'd0, 4'd8, 4'd7, 11'h000, 4'd8, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{2'd0, 4'd13, 4'd1, 11'h000, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{2'd3, 4'd0, 4'd0, 11'h000, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{2'd2, 4'd0, 4'd0, 11'h001, 4'd1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0};

        e_save = '{4'd1, 4'd3, 4'd6, 4'd8};
        e_rest = '{4'd9, 4'd10, 4'd11};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_rso", rso, 0);
        check("rst_rsi", rsi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_grant", grant_id, 0);
        check("rst_we", mem_we, 0);
        r = 1'b0;

        // Single-cycle commands from the table
        for (int i = 0; i < 13; i++) begin
            issue(vecs[i].op, vecs[i].src, vecs[i].dst, vecs[i].mask);
            check($sformatf("v%0d_rso", i), rso, vecs[i].e_rso);
            check($sformatf("v%0d_rsi", i), rsi, vecs[i].e_rsi);
            check($sformatf("v%0d_we", i), mem_we, vecs[i].e_we);
            check($sformatf("v%0d_oe", i), mem_oe, vecs[i].e_oe);
            check($sformatf("v%0d_done", i), done, vecs[i].e_done);
            check($sformatf("v%0d_err", i), err, vecs[i].e_err);
            check($sformatf("v%0d_busy", i), busy, 1);
            check($sformatf("v%0d_grant", i), grant_id, 0);
            @(negedge clk);
            check($sformatf("v%0d_idle_rso", i), rso, 0);
            check($sformatf("v%0d_idle_done", i), done, 0);
            check($sformatf("v%0d_idle_busy", i), busy, 0);
        end

        // SAVE burst, mask 0x0A5
        issue(2'd2, 4'd0, 4'd0, 11'h0A5);
        for (int b = 0; b < 4; b++) begin
            check($sformatf("save_b%0d_rso", b), rso, e_save[b]);
            check($sformatf("save_b%0d_rsi", b), rsi, 0);
            check($sformatf("save_b%0d_we", b), mem_we, 1);
            check($sformatf("save_b%0d_oe", b), mem_oe, 0);
            check($sformatf("save_b%0d_ofs", b), mem_ofs, b);
            check($sformatf("save_b%0d_done", b), done, (b == 3) ? 1 : 0);
            @(negedge clk);
        end
        check("save_end_busy", busy, 0);
        check("save_end_we", mem_we, 0);

        // RESTORE burst, mask 0x700
        issue(2'd3, 4'd0, 4'd0, 11'h700);
        for (int b = 0; b < 3; b++) begin
            check($sformatf("rest_b%0d_rsi", b), rsi, e_rest[b]);
            check($sformatf("rest_b%0d_rso", b), rso, 0);
            check($sformatf("rest_b%0d_oe", b), mem_oe, 1);
            check($sformatf("rest_b%0d_we", b), mem_we, 0);
            check($sformatf("rest_b%0d_ofs", b), mem_ofs, b);
            check($sformatf("rest_b%0d_done", b), done, (b == 2) ? 1 : 0);
            @(negedge clk);
        end
        check("rest_end_oe", mem_oe, 0);

        // Arbitration: both requesters hold MOV commands
        do_reset();
        req0_op = 2'd0; req0_src = 4'd1; req0_dst = 4'd2;
        req1_op = 2'd0; req1_src = 4'd3; req1_dst = 4'd4;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        ng = 0;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            @(negedge clk);
            if (done) begin
                g_rr[ng] = grant_id;
                g_fp[ng] = fp_grant;
                check($sformatf("arb%0d_fp_done", ng), fp_done, 1);
                check($sformatf("arb%0d_rso", ng), rso, grant_id ? 3 : 1);
                ng++;
                if (ng == 4) begin
                    req0_valid = 1'b0;
                    req1_valid = 1'b0;
                end
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("arb_count", ng, 4);
        for (int k = 0; k < ng; k++) begin
            check($sformatf("arb%0d_rr_grant", k), g_rr[k], k % 2);
            check($sformatf("arb%0d_fp_grant", k), g_fp[k], 0);
        end

        // Reset on beat 2 of a 5-beat SAVE
        do_reset();
        issue(2'd2, 4'd0, 4'd0, 11'h01F);
        check("abort_b0_rso", rso, 1);
        @(negedge clk);
        check("abort_b1_rso", rso, 2);
        r = 1'b1;
        @(negedge clk);
        check("abort_rso", rso, 0);
        check("abort_we", mem_we, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_ready", req0_ready, 0);
        r = 1'b0;
        req0_op = 2'd0; req0_src = 4'd1; req0_dst = 4'd2; req0_mask = '0;
        req0_valid = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (req0_ready) begin
                seen = 1'b1;
                break;
            end
        end
        check("post_reset_ready", seen, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        check("post_reset_mov_rso", rso, 1);
        check("post_reset_mov_done", done, 1);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
